ram_port_arbiter: RTL and testbench

- Shares the single-port data RAM between two requesters: instruction fetch (IF, read-only, word) and load/store unit (LS, read/write, byte/half/word, signed/unsigned).
- Sits between the core pipeline and the RAM.
- Issues at most one RAM operation per cycle.
- Screens illegal accesses (misaligned, bad mode, out of range) so the RAM never receives them.
- Routes the one-cycle-late RAM read data back to the requester that issued the read.

---
 rtl/ram_port_arbiter_pkg.sv | 15 +
 rtl/ram_access_check.sv | 18 +
 rtl/ram_port_arbiter.sv | 100 ++++++++++
 tb/tb_ram_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared RAM access modes, read-owner tags and address-range helper.
package ram_port_arbiter_pkg;
  localparam logic [1:0] RAM_MODE_BYTE = 2'd0;
  localparam logic [1:0] RAM_MODE_HALF = 2'd1;
  localparam logic [1:0] RAM_MODE_WORD = 2'd2;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;
  function automatic logic [63:0] addr_limit(input int mem_words);
    return 64'(mem_words) * 64'(WORD_BYTES);
  endfunction
endpackage

// File: rtl/ram_access_check.sv
// ram_access_check: flags misaligned, bad-mode or out-of-range RAM accesses.
module ram_access_check
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 65536
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        mode,
  output logic              illegal
);
  localparam logic [63:0] LIMIT = addr_limit(MEM_WORDS);
  always_comb
    illegal = mode == 2'd3
           || (mode == RAM_MODE_HALF && addr[1:0] == 2'd3)
           || (mode == RAM_MODE_WORD && addr[1:0] != 2'd0)
           || 64'(addr) >= LIMIT;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single-port data RAM between fetch (IF) and load/store (LS).
// ARB_ROUND_ROBIN_EN: under contention the port not granted last time wins instead of fixed LS priority.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int MEM_WORDS = 65536,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [1:0]        ls_mode,
  input  logic              ls_signed,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic              ram_we,
  output logic [31:0]       ram_r_addr,
  output logic [31:0]       ram_w_addr,
  output logic [31:0]       ram_w_data,
  output logic [1:0]        ram_write_mode,
  output logic [1:0]        ram_read_mode,
  output logic              ram_read_signed,
  input  logic [31:0]       ram_r_data
);
  logic              ls_first, illegal, rd;
  logic [ADDR_W-1:0] g_addr;
  logic [1:0]        g_mode;
  owner_t            owner, owner_nxt;
  logic              if_err_q, ls_err_q;
  logic [31:0]       if_hold, ls_hold;
`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_ls;
  always_ff @(posedge clk)
    if (rst) ptr_ls <= 1'b1;
    else if (if_gnt || ls_gnt) ptr_ls <= if_gnt;
  always_comb ls_first = ptr_ls;
`else
  always_comb ls_first = 1'b1;
`endif
  always_comb begin
    ls_gnt = !rst && ls_req && (!if_req || ls_first);
    if_gnt = !rst && if_req && !ls_gnt;
    g_addr = ls_gnt ? ls_addr : if_addr;
    g_mode = ls_gnt ? ls_mode : RAM_MODE_WORD;
  end
  ram_access_check #(
    .ADDR_W   (ADDR_W),
    .MEM_WORDS(MEM_WORDS)
  ) u_check (
    .addr   (g_addr),
    .mode   (g_mode),
    .illegal(illegal)
  );
  // Illegal requests are consumed but never reach the RAM.
  always_comb begin
    ram_we          = ls_gnt && ls_we && !illegal;
    rd              = (if_gnt || (ls_gnt && !ls_we)) && !illegal;
    ram_w_addr      = ram_we ? 32'(ls_addr) : '0;
    ram_w_data      = ram_we ? ls_wdata : '0;
    ram_write_mode  = ram_we ? ls_mode : '0;
    ram_r_addr      = rd ? 32'(g_addr) : '0;
    ram_read_mode   = rd ? g_mode : '0;
    ram_read_signed = rd && ls_gnt && ls_signed;
    owner_nxt       = !rd ? OWN_NONE : ls_gnt ? OWN_LS : OWN_IF;
  end
  always_ff @(posedge clk)
    if (rst) begin
      owner    <= OWN_NONE;
      if_err_q <= 1'b0;
      ls_err_q <= 1'b0;
      if_hold  <= '0;
      ls_hold  <= '0;
    end else begin
      owner    <= owner_nxt;
      if_err_q <= if_gnt && illegal;
      ls_err_q <= ls_gnt && illegal;
      if_hold  <= if_rdata;
      ls_hold  <= ls_rdata;
    end
  // Gating with rst kills any response still in flight when reset arrives.
  always_comb begin
    if_rvalid = !rst && owner == OWN_IF;
    ls_rvalid = !rst && owner == OWN_LS;
    if_err    = !rst && if_err_q;
    ls_err    = !rst && ls_err_q;
    if_rdata  = rst ? '0 : owner == OWN_IF ? ram_r_data : if_hold;
    ls_rdata  = rst ? '0 : owner == OWN_LS ? ram_r_data : ls_hold;
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random traffic with a RAM model and a response scoreboard.
module tb_ram_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr = '0, if_rdata;
  logic        ls_req = 1'b0, ls_we = 1'b0, ls_signed = 1'b0, ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_addr = '0, ls_wdata = '0, ls_rdata;
  logic [1:0]  ls_mode = '0;
  logic        ram_we, ram_read_signed;
  logic [31:0] ram_r_addr, ram_w_addr, ram_w_data, ram_r_data;
  logic [1:0]  ram_write_mode, ram_read_mode;

  int n_checks = 0, n_errors = 0, cyc = 0;
  logic [31:0] ram [0:255];
  logic [31:0] ref_mem [0:255];
  typedef struct { int due; logic [3:0] flags; logic [31:0] data; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [3:0] got;
  logic exp_we;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_mode(ls_mode), .ls_signed(ls_signed), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .ram_we(ram_we), .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr),
    .ram_w_data(ram_w_data), .ram_write_mode(ram_write_mode), .ram_read_mode(ram_read_mode),
    .ram_read_signed(ram_read_signed), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] x);
    n_checks++;
    assert (g === x) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, g, x);
    end
  endtask

  function automatic logic bad(input logic [31:0] a, input logic [1:0] m);
    return m == 2'd3 || (m == 2'd1 && a[1:0] == 2'd3) || (m == 2'd2 && a[1:0] != 2'd0) || a >= 32'h40000;
  endfunction

  function automatic logic [31:0] put(input logic [31:0] w, input logic [1:0] off, input logic [1:0] m, input logic [31:0] d);
    logic [31:0] r = w;
    if (m == 2'd0) r[8*off +: 8] = d[7:0];
    else if (m == 2'd1) r[8*off +: 16] = d[15:0];
    else r = d;
    return r;
  endfunction

  function automatic logic [31:0] get(input logic [31:0] w, input logic [1:0] off, input logic [1:0] m, input logic s);
    logic [31:0] x = w >> (8*off);
    if (m == 2'd0) return {{24{s & x[7]}}, x[7:0]};
    if (m == 2'd1) return {{16{s & x[15]}}, x[15:0]};
    return x;
  endfunction

  // RAM model: registered read, writes land at the edge closing the grant cycle.
  always @(posedge clk) begin
    if (ram_we) ram[ram_w_addr[9:2]] <= put(ram[ram_w_addr[9:2]], ram_w_addr[1:0], ram_write_mode, ram_w_data);
    ram_r_data <= get(ram[ram_r_addr[9:2]], ram_r_addr[1:0], ram_read_mode, ram_read_signed);
  end

  // Scoreboard: compare responses due this cycle, then push expectations for this cycle's grants.
  always @(negedge clk) begin
    got = {if_rvalid, if_err, ls_rvalid, ls_err};
    if (rst) begin
      sb.delete();
      chk("rst_quiet", {25'd0, if_gnt, ls_gnt, ram_we, got}, 32'd0);
      chk("rst_rdata", if_rdata | ls_rdata, 32'd0);
    end else begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("resp_flags", {28'd0, got}, {28'd0, e.flags});
        if (e.flags[3]) chk("if_rdata", if_rdata, e.data);
        if (e.flags[1]) chk("ls_rdata", ls_rdata, e.data);
      end else chk("no_resp", {28'd0, got}, 32'd0);
      chk("gnt_noreq", {30'd0, if_gnt & ~if_req, ls_gnt & ~ls_req}, 32'd0);
      exp_we = ls_gnt && ls_we && !bad(ls_addr, ls_mode);
      chk("ram_we", {31'd0, ram_we}, {31'd0, exp_we});
      if (exp_we) chk("ram_w_addr", ram_w_addr, ls_addr);
      if (ls_gnt) begin
        if (bad(ls_addr, ls_mode)) sb.push_back('{cyc + 1, 4'b0001, 32'd0});
        else if (ls_we) ref_mem[ls_addr[9:2]] = put(ref_mem[ls_addr[9:2]], ls_addr[1:0], ls_mode, ls_wdata);
        else sb.push_back('{cyc + 1, 4'b0010, get(ref_mem[ls_addr[9:2]], ls_addr[1:0], ls_mode, ls_signed)});
      end
      if (if_gnt) begin
        if (bad(if_addr, 2'd2)) sb.push_back('{cyc + 1, 4'b0100, 32'd0});
        else sb.push_back('{cyc + 1, 4'b1000, ref_mem[if_addr[9:2]]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bad_addr [4] = '{32'h43, 32'h03, 32'h10, 32'h40000};
  logic [1:0]  bad_mode [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
  logic        bad_we   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [3:0]  rr_pat;
  logic        g_if, g_ls;
  int          n_req = 0, n_gnt = 0, w_if = 0, w_ls = 0, max_wait = 0;
  logic [31:0] a;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = (i * 32'h01010101) ^ 32'hA5C30F69;
      ref_mem[i] = ram[i];
    end
    ram[4] = 32'h12345678; ref_mem[4] = 32'h12345678;
    ram[8] = 32'h11803344; ref_mem[8] = 32'h11803344;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
    chk("reset_err", {30'd0, if_err, ls_err}, 32'd0);
    chk("reset_rdata", if_rdata | ls_rdata, 32'd0);
    // Lone fetch.
    tick();
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    chk("t1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h12345678);
    chk("t1_ls_idle", {31'd0, ls_rvalid} | ls_rdata, 32'd0);
    chk("t1_ram_idle", ram_r_addr | ram_w_addr | ram_w_data | {28'd0, ram_read_mode, ram_write_mode}, 32'd0);
    // Simultaneous LS signed byte load and fetch.
    tick();
    if_req = 1'b1; if_addr = 32'h10;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h22; ls_mode = 2'd0; ls_signed = 1'b1;
    @(negedge clk);
    chk("t2_ls_first", {30'd0, ls_gnt, if_gnt}, 32'd2);
    chk("t2_r_addr", ram_r_addr, 32'h22);
    chk("t2_r_signed", {31'd0, ram_read_signed}, 32'd1);
    tick();
    ls_req = 1'b0;
    @(negedge clk);
    chk("t2_ls_rdata", ls_rdata, 32'hFFFFFF80);
    chk("t2_if_gnt", {31'd0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    chk("t2_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t2_ls_hold", ls_rdata, 32'hFFFFFF80);
    // Both held continuously.
`ifdef ARB_ROUND_ROBIN_EN
    rr_pat = 4'b0101;
`else
    rr_pat = 4'b1111;
`endif
    tick();
    if_req = 1'b1; ls_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_contend", {30'd0, ls_gnt, if_gnt}, {30'd0, rr_pat[k], ~rr_pat[k]});
      tick();
    end
    if_req = 1'b0; ls_req = 1'b0;
    // Store half then load it back.
    tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h42; ls_mode = 2'd1; ls_wdata = 32'h1234BEEF;
    @(negedge clk);
    chk("t3_st_gnt", {31'd0, ls_gnt}, 32'd1);
    chk("t3_wmode", {30'd0, ram_write_mode}, 32'd1);
    chk("t3_wdata", ram_w_data, 32'h1234BEEF);
    tick();
    ls_we = 1'b0; ls_signed = 1'b0;
    @(negedge clk);
    chk("t3_ld_gnt", {31'd0, ls_gnt}, 32'd1);
    chk("t3_ld_nowe", {31'd0, ram_we}, 32'd0);
    tick();
    ls_req = 1'b0;
    @(negedge clk);
    chk("t3_ld_data", ls_rdata, 32'h0000BEEF);
    // Illegal accesses.
    for (int k = 0; k < 4; k++) begin
      tick();
      ls_req = 1'b1; ls_addr = bad_addr[k]; ls_mode = bad_mode[k]; ls_we = bad_we[k];
      @(negedge clk);
      chk("t4_gnt", {31'd0, ls_gnt}, 32'd1);
      chk("t4_no_we", {31'd0, ram_we}, 32'd0);
      tick();
      ls_req = 1'b0;
      @(negedge clk);
      chk("t4_err", {30'd0, ls_err, ls_rvalid}, 32'd2);
      tick();
      @(negedge clk);
      chk("t4_err_pulse", {31'd0, ls_err}, 32'd0);
    end
    ls_we = 1'b0;
    // Reset while a fetch is outstanding.
    tick();
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("t5_gnt", {31'd0, if_gnt}, 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_killed", {30'd0, if_rvalid, if_gnt}, 32'd0);
    tick();
    @(negedge clk);
    chk("t5_in_rst", {31'd0, if_rvalid}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_gnt", {31'd0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    chk("t5_post_data", if_rdata, 32'h12345678);
    // Random legal traffic.
    g_ls = 1'b0;
    for (int c = 0; c < 110; c++) begin
      if (c < 100 && !if_req && $urandom_range(1) == 1) begin
        if_req = 1'b1; if_addr = 32'($urandom_range(15)) * 4; n_req++; w_if = 0;
      end
      if (c < 100 && !ls_req && !g_ls && $urandom_range(1) == 1) begin
        ls_req = 1'b1; ls_we = 1'($urandom_range(1)); ls_mode = 2'($urandom_range(2));
        a = 32'($urandom_range(63));
        if (ls_mode == 2'd2) a[1:0] = 2'd0;
        if (ls_mode == 2'd1 && a[1:0] == 2'd3) a[1:0] = 2'd2;
        ls_addr = a; ls_wdata = $urandom; ls_signed = 1'($urandom_range(1)); n_req++; w_ls = 0;
      end
      @(negedge clk);
      g_if = if_gnt; g_ls = ls_gnt;
      if (if_req) begin if (g_if) n_gnt++; else w_if++; end
      if (ls_req) begin if (g_ls) n_gnt++; else w_ls++; end
      if (w_if > max_wait) max_wait = w_if;
      if (w_ls > max_wait) max_wait = w_ls;
      tick();
      if (g_if) if_req = 1'b0;
      if (g_ls) ls_req = 1'b0;
    end
    repeat (3) tick();
    chk("rnd_gnt_count", n_gnt, n_req);
    chk("rnd_wait_bound", {31'd0, max_wait <= 2}, 32'd1);
    chk("rnd_sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
